// File: rtl/dmx512_pkg.sv
// Shared DMX512 definitions for the receiver and the transmitter.
//   BIT_TIME / BREAK_MIN / MAB_MIN : receiver timing in 50 MHz clocks
//   TX_*                           : transmitter frame timing in 50 MHz clocks
//   rx_state_e                     : receiver FSM state encoding
package dmx512_pkg;

    localparam int unsigned BIT_TIME  = 200;   // 4 us per bit
    localparam int unsigned BREAK_MIN = 4400;  // 88 us of low line qualifies a break
    localparam int unsigned MAB_MIN   = 400;   // 8 us minimum mark-after-break

    localparam int unsigned TX_IDLE      = 2500;
    localparam int unsigned TX_BREAK     = 5000;
    localparam int unsigned TX_MAB       = 600;
    localparam int unsigned TX_STOP_BITS = 2;

    localparam int unsigned NUM_SLOTS = 512;

    typedef enum logic [2:0] {
        StIdle,
        StBreak,
        StMab,
        StStart,
        StData,
        StStop,
        StGap
    } rx_state_e;

endpackage

// File: rtl/dmx512_rx_sync.sv
// Two-flop synchronizer for the raw DMX line plus single-cycle edge pulses.
//   clk, rst_n : system clock, asynchronous active-low reset
//   dmx_in     : raw line, asynchronous to clk
//   line       : synchronized line level
//   fall, rise : one-cycle pulses on synchronized falling / rising edges
module dmx512_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic dmx_in,
    output logic line,
    output logic fall,
    output logic rise
);

    logic meta_q, sync_q, prev_q;

    // Reset to the idle (mark) level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= dmx_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign line = sync_q;
    assign fall = prev_q & ~sync_q;
    assign rise = ~prev_q & sync_q;

endmodule

// File: rtl/dmx512_rx.sv
// DMX512 receiver: break/MAB detection, slot deframing, null-start-code packet
// decode, slot streaming and a 512-byte universe buffer with registered read.
//   clk, rst_n            : 50 MHz clock, asynchronous active-low reset
//   dmx_in                : raw DMX line
//   slot_valid/addr/data  : one-cycle pulse per accepted data slot (1..512)
//   packet_done           : one-cycle pulse at end of an accepted packet
//   slot_count            : data slots in last completed packet (held)
//   frame_err             : one-cycle pulse on start/stop-bit violation
//   read_addr/read_data   : universe buffer read port, 1-cycle latency
module dmx512_rx
    import dmx512_pkg::*;
#(
    parameter int unsigned BitTime  = BIT_TIME,
    parameter int unsigned BreakMin = BREAK_MIN,
    parameter int unsigned MabMin   = MAB_MIN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dmx_in,
    output logic       slot_valid,
    output logic [9:0] slot_addr,
    output logic [7:0] slot_data,
    output logic       packet_done,
    output logic [9:0] slot_count,
    output logic       frame_err,
    input  logic [9:0] read_addr,
    output logic [7:0] read_data
);

    localparam logic [12:0] HalfBit  = 13'(BitTime / 2);
    localparam logic [12:0] BitStep  = 13'(BitTime);
    localparam logic [12:0] BreakLen = 13'(BreakMin);
    localparam logic [12:0] MabLen   = 13'(MabMin);
    localparam logic [12:0] CntMax   = 13'h1fff;
    localparam logic [9:0]  LastSlot = 10'(NUM_SLOTS);

    logic line, fall, rise;

    dmx512_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .dmx_in (dmx_in),
        .line   (line),
        .fall   (fall),
        .rise   (rise)
    );

    rx_state_e   state_q, state_d;
    logic [12:0] low_run_q, low_run_d;
    logic [12:0] timer_q, timer_d;
    logic [12:0] sample_at_q, sample_at_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [9:0]  slot_q, slot_d;
    logic [9:0]  last_acc_q, last_acc_d;  // last accepted data slot of the open packet, 0 = none
    logic        slot_valid_q, slot_valid_d;
    logic [9:0]  slot_addr_q, slot_addr_d;
    logic [7:0]  slot_data_q, slot_data_d;
    logic        packet_done_q, packet_done_d;
    logic [9:0]  slot_count_q, slot_count_d;
    logic        frame_err_q, frame_err_d;
    logic        brk_hit, sample_now;

    always_comb begin
        state_d       = state_q;
        low_run_d     = line ? 13'd0 : ((low_run_q == CntMax) ? low_run_q : low_run_q + 13'd1);
        timer_d       = (timer_q == CntMax) ? timer_q : timer_q + 13'd1;
        sample_at_d   = sample_at_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        slot_d        = slot_q;
        last_acc_d    = last_acc_q;
        slot_valid_d  = 1'b0;
        slot_addr_d   = slot_addr_q;
        slot_data_d   = slot_data_q;
        packet_done_d = 1'b0;
        slot_count_d  = slot_count_q;
        frame_err_d   = 1'b0;

        // Fires only in the cycle the low run first reaches the threshold.
        brk_hit    = (low_run_d == BreakLen);
        sample_now = (timer_q == sample_at_q);

        case (state_q)
            StIdle: ;
            StBreak: begin
                if (rise) begin
                    state_d = StMab;
                    timer_d = '0;
                end
            end
            StMab: begin
                if (fall) begin
                    if (timer_q >= MabLen) begin
                        state_d     = StStart;
                        timer_d     = '0;
                        sample_at_d = HalfBit;
                        slot_d      = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StStart: begin
                if (sample_now) begin
                    if (line) begin
                        state_d     = StIdle;
                        frame_err_d = 1'b1;
                    end else begin
                        state_d     = StData;
                        sample_at_d = sample_at_q + BitStep;
                        bit_cnt_d   = '0;
                    end
                end
            end
            StData: begin
                if (sample_now) begin
                    shift_d     = {line, shift_q[7:1]};
                    sample_at_d = sample_at_q + BitStep;
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (sample_now) begin
                    if (!line) begin
                        state_d     = StIdle;
                        frame_err_d = 1'b1;
                    end else if (slot_q == '0) begin
                        // Only the null start code opens a packet we decode.
                        state_d = (shift_q == 8'h00) ? StGap : StIdle;
                    end else begin
                        slot_valid_d = 1'b1;
                        slot_addr_d  = slot_q;
                        slot_data_d  = shift_q;
                        last_acc_d   = slot_q;
                        if (slot_q == LastSlot) begin
                            packet_done_d = 1'b1;
                            slot_count_d  = LastSlot;
                            last_acc_d    = '0;
                            state_d       = StIdle;
                        end else begin
                            state_d = StGap;
                        end
                    end
                end
            end
            StGap: begin
                if (fall) begin
                    state_d     = StStart;
                    timer_d     = '0;
                    sample_at_d = HalfBit;
                    slot_d      = slot_q + 10'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A qualified break wins over anything decided above and closes an open packet.
        if (brk_hit) begin
            state_d      = StBreak;
            slot_valid_d = 1'b0;
            frame_err_d  = 1'b0;
            if (last_acc_q != '0) begin
                packet_done_d = 1'b1;
                slot_count_d  = last_acc_q;
            end else begin
                packet_done_d = 1'b0;
            end
            last_acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            low_run_q     <= '0;
            timer_q       <= '0;
            sample_at_q   <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            slot_q        <= '0;
            last_acc_q    <= '0;
            slot_valid_q  <= 1'b0;
            slot_addr_q   <= '0;
            slot_data_q   <= '0;
            packet_done_q <= 1'b0;
            slot_count_q  <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            low_run_q     <= low_run_d;
            timer_q       <= timer_d;
            sample_at_q   <= sample_at_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            slot_q        <= slot_d;
            last_acc_q    <= last_acc_d;
            slot_valid_q  <= slot_valid_d;
            slot_addr_q   <= slot_addr_d;
            slot_data_q   <= slot_data_d;
            packet_done_q <= packet_done_d;
            slot_count_q  <= slot_count_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Universe buffer, slot n stored at index n-1. Written in the slot_valid cycle.
    logic [7:0] mem_q [NUM_SLOTS];
    logic [7:0] read_q;
    logic [8:0] wr_idx, rd_idx;
    logic       rd_hit;

    assign wr_idx = 9'(slot_addr_q - 10'd1);
    assign rd_idx = 9'(read_addr - 10'd1);
    assign rd_hit = (read_addr != 10'd0) && (read_addr <= LastSlot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: 8'h00};
            read_q <= 8'h00;
        end else begin
            if (slot_valid_q) begin
                mem_q[wr_idx] <= slot_data_q;
            end
            read_q <= rd_hit ? mem_q[rd_idx] : 8'h00;
        end
    end

    assign slot_valid  = slot_valid_q;
    assign slot_addr   = slot_addr_q;
    assign slot_data   = slot_data_q;
    assign packet_done = packet_done_q;
    assign slot_count  = slot_count_q;
    assign frame_err   = frame_err_q;
    assign read_data   = read_q;

endmodule

// File: tb/tb_dmx512_rx.sv
// Randomized DMX512 receiver bench. Timing is scaled down 25x (8 clocks/bit) so a
// full 512-slot universe fits in a short run; all ratios match the real link.
module tb_dmx512_rx;

    localparam int BT = 8;    // clocks per bit
    localparam int BM = 176;  // break qualification length
    localparam int MM = 16;   // minimum MAB

    logic       clk;
    logic       rst_n;
    logic       dmx_in;
    logic       slot_valid;
    logic [9:0] slot_addr;
    logic [7:0] slot_data;
    logic       packet_done;
    logic [9:0] slot_count;
    logic       frame_err;
    logic [9:0] read_addr;
    logic [7:0] read_data;

    dmx512_rx #(
        .BitTime  (BT),
        .BreakMin (BM),
        .MabMin   (MM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dmx_in      (dmx_in),
        .slot_valid  (slot_valid),
        .slot_addr   (slot_addr),
        .slot_data   (slot_data),
        .packet_done (packet_done),
        .slot_count  (slot_count),
        .frame_err   (frame_err),
        .read_addr   (read_addr),
        .read_data   (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } slot_t;

    // Reference model state.
    slot_t      exp_slots[$];
    int         exp_done[$];
    int         exp_ferr;
    logic [7:0] ref_buf [0:512];
    int         open_cnt;   // last accepted slot of an unclosed null packet
    bit         rx_active;  // receiver is inside a null packet waiting for more slots

    int vectors;
    int miscompares;

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        slot_t e;
        int    d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (slot_valid) begin
                    vectors++;
                    if (exp_slots.size() == 0) begin
                        miscompares++;
                        $display("FAIL slot: unexpected slot_valid addr=%0d data=%02h", slot_addr,
                                 slot_data);
                    end else begin
                        e = exp_slots.pop_front();
                        if (slot_addr !== e.addr || slot_data !== e.data) begin
                            miscompares++;
                            $display("FAIL slot: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                                     slot_addr, slot_data, e.addr, e.data);
                        end
                    end
                end
                if (packet_done) begin
                    vectors++;
                    if (exp_done.size() == 0) begin
                        miscompares++;
                        $display("FAIL done: unexpected packet_done slot_count=%0d", slot_count);
                    end else begin
                        d = exp_done.pop_front();
                        if (slot_count !== 10'(d)) begin
                            miscompares++;
                            $display("FAIL done: slot_count=%0d expected %0d", slot_count, d);
                        end
                    end
                end
                if (frame_err) begin
                    vectors++;
                    if (exp_ferr == 0) begin
                        miscompares++;
                        $display("FAIL frame_err: unexpected pulse, expected none");
                    end else begin
                        exp_ferr--;
                    end
                end
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 150000 cycles, expected completion");
        $fatal(1);
    end

    task automatic drive(input logic v, input int n);
        dmx_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        drive(1'b0, BT);
        for (int i = 0; i < 8; i++) drive(b[i], BT);
        if (good_stop) begin
            drive(1'b1, 2 * BT);
        end else begin
            drive(1'b0, BT);
            drive(1'b1, BT);
        end
    endtask

    // One packet on the wire; expectations derived from the link rules.
    task automatic send_packet(input int idle, input int brk, input int mab, input logic [7:0] sc,
                               input int n, input int bad_slot, input bit pattern);
        logic [7:0] d;
        bit         listening;
        drive(1'b1, idle);
        if (brk >= BM) begin
            // The break's leading low is first seen as a start bit with a low stop bit.
            if (rx_active) exp_ferr++;
            if (open_cnt != 0) exp_done.push_back(open_cnt);
            open_cnt  = 0;
            rx_active = 1'b0;
        end
        drive(1'b0, brk);
        drive(1'b1, mab);
        listening = (brk >= BM) && (mab > MM) && (sc == 8'h00);
        rx_active = listening;
        send_byte(sc, 1'b1);
        for (int s = 1; s <= n; s++) begin
            if (pattern) d = (s == 1) ? 8'h55 : (s == 512) ? 8'hAA : 8'(s);
            else         d = 8'($urandom);
            if (listening) begin
                if (s == bad_slot) begin
                    exp_ferr++;
                    listening = 1'b0;
                    rx_active = 1'b0;
                end else begin
                    exp_slots.push_back('{addr: 10'(s), data: d});
                    ref_buf[s] = d;
                    open_cnt   = s;
                    if (s == 512) begin
                        exp_done.push_back(512);
                        open_cnt  = 0;
                        listening = 1'b0;
                        rx_active = 1'b0;
                    end
                end
            end
            send_byte(d, s != bad_slot);
        end
    endtask

    task automatic drain();
        drive(1'b1, 4 * BT * 11);
    endtask

    task automatic readback(input string tag);
        logic [7:0] e;
        for (int a = 0; a <= 516; a++) begin
            read_addr = (a == 516) ? 10'h3ff : 10'(a);
            @(negedge clk);
            e = (a >= 1 && a <= 512) ? ref_buf[a] : 8'h00;
            vectors++;
            if (read_data !== e) begin
                miscompares++;
                $display("FAIL %s: read_addr=%0d read_data=%02h expected %02h", tag, read_addr,
                         read_data, e);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        vectors++;
        if ({slot_valid, slot_addr, slot_data, packet_done, slot_count, frame_err, read_data} !== '0)
        begin
            miscompares++;
            $display("FAIL %s: outputs v=%b a=%0d d=%02h pd=%b cnt=%0d fe=%b rd=%02h, expected all 0",
                     tag, slot_valid, slot_addr, slot_data, packet_done, slot_count, frame_err,
                     read_data);
        end
    endtask

    task automatic check_empty(input string tag);
        vectors++;
        if (exp_slots.size() != 0 || exp_done.size() != 0 || exp_ferr != 0) begin
            miscompares++;
            $display("FAIL %s: pending slots=%0d done=%0d frame_err=%0d, expected 0/0/0", tag,
                     exp_slots.size(), exp_done.size(), exp_ferr);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_ferr    = 0;
        open_cnt    = 0;
        rx_active   = 1'b0;
        for (int i = 0; i <= 512; i++) ref_buf[i] = 8'h00;
        rst_n     = 1'b0;
        dmx_in    = 1'b1;
        read_addr = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            dmx_in    = 1'($urandom);
            read_addr = 10'($urandom_range(1, 512));
            @(negedge clk);
            check_reset("reset");
        end
        dmx_in = 1'b1;
        rst_n  = 1'b1;
        repeat (5) @(negedge clk);
        readback("reset buffer");

        // Full universe at transmitter timing (scaled).
        send_packet(100, 200, 24, 8'h00, 512, 0, 1'b1);
        drain();
        check_empty("full packet");
        readback("full packet buffer");

        // Short break ignored, then rejected start code, then a normal null packet.
        send_packet(40, 160, 24, 8'h00, 10, 0, 1'b0);
        send_packet(40, 200, 24, 8'h17, 20, 0, 1'b0);
        drain();
        check_empty("short break / alt start code");
        readback("alt start code buffer");
        send_packet(40, 200, 24, 8'h00, 30, 0, 1'b0);
        send_packet(40, 200, 24, 8'h00, 24, 0, 1'b0);
        drain();
        readback("partial packet buffer");

        // Exact-threshold break closes the 24-slot packet and opens a new one.
        send_packet(40, BM, 24, 8'h00, 40, 0, 1'b0);
        // Bad stop bit in slot 3.
        send_packet(40, 200, 24, 8'h00, 6, 3, 1'b0);
        drain();
        check_empty("frame error");
        readback("frame error buffer");

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset("mid-run reset");
        end
        for (int i = 0; i <= 512; i++) ref_buf[i] = 8'h00;
        open_cnt  = 0;
        rx_active = 1'b0;
        rst_n     = 1'b1;

        // MAB too short: packet ignored.
        send_packet(40, 200, 12, 8'h00, 10, 0, 1'b0);
        drain();
        check_empty("short mab");
        readback("short mab buffer");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmx512_rx.md
# dmx512_rx

DMX512 receiver: the receive end of the DMX512 link the team's transmitter drives. It samples the serial line at 50 MHz (250 kbaud, 200 clocks/bit) and detects BREAK / MAB. Packets with a null start code are decoded; each data slot (1..512) is streamed out and mirrored into a 512-byte universe buffer with a registered read port. Used for loopback verification and for a DMX-in front end.

## Interface
- BIT_TIME, 200, clocks per bit (4 µs at 50 MHz)
- BREAK_MIN, 4400, consecutive low clocks that qualify a BREAK (88 µs)
- MAB_MIN, 400, minimum high clocks for a valid MAB (8 µs)
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- dmx_in  in  1  raw DMX line, asynchronous to clk
- slot_valid  out  1  one-cycle pulse: slot_addr/slot_data valid
- slot_addr  out  10  data slot number, 1..512
- slot_data  out  8  received slot byte
- packet_done  out  1  one-cycle pulse at end of an accepted packet
- slot_count  out  10  data slots in last completed packet (held)
- frame_err  out  1  one-cycle pulse on start/stop-bit violation
- read_addr  in  10  universe buffer read address
- read_data  out  8  buffer byte, registered, 1-cycle latency

## Operation
- dmx_in passes through a 2-flop synchronizer. Falling edge = synced low while previous synced value high.
- low_run: 13-bit saturating count of consecutive synced-low clocks, cleared on any high. low_run reaching BREAK_MIN forces state BREAK from any state; this overrides every other transition in the same cycle.
- States:
  - IDLE: wait for a break.
  - BREAK: rising edge -> MAB, clear timer.
  - MAB: falling edge -> if timer ≥ MAB_MIN, go to START with slot=0; else go to IDLE.
  - START: bit timer cleared at the falling edge. At timer==100, line high -> IDLE (false start, frame_err); else -> DATA.
  - DATA: sample 8 bits LSB-first at timer==300,500,…,1700.
  - STOP: sample at timer==1900. Low -> frame_err, IDLE, slot discarded. High -> slot accepted, go to GAP.
  - GAP: falling edge -> START, slot+1.
- Slot 0 is the start code. Non-zero -> IDLE; no outputs, buffer untouched.
- Accepted slot 1..512: slot_valid pulse, buffer[slot] written. Slot 512 accepted -> packet_done, slot_count=512, IDLE.
- Break arriving while ≥1 data slot of a null-start-code packet has been accepted -> packet_done, slot_count = last accepted slot. A partial slot in progress is discarded.
- Buffer is not double-buffered; slots not received keep their prior values.
- read_addr 0 or >512 returns 0x00.

## Timing
- Reset values: all outputs 0, slot_count 0, buffer all 0x00, state IDLE, low_run 0.
- Input-to-edge latency: 2 clocks (synchronizer).
- slot_valid, slot_addr, slot_data and the buffer write occur the cycle after the STOP sample (timer==1900).
- packet_done occurs in the same cycle as the slot-512 slot_valid, or in the cycle BREAK is entered.
- read_data updates 1 clock after read_addr. A write and read to the same address in the same cycle returns the old value.
- Timer is 13 bits and is cleared on every state-defining edge, so it never wraps within a slot. low_run saturates at 8191.
- Reset is asynchronous mid-packet: return to IDLE; the next packet is accepted only after a full break.

## Structure
- dmx512_pkg holds BIT_TIME, BREAK_MIN, MAB_MIN, transmit timing constants and the rx state enum (IDLE, BREAK, MAB, START, DATA, STOP, GAP), shared with the transmitter.
- One sub-module, dmx512_rx_sync: 2-flop synchronizer plus fall/rise edge pulses.

## Test plan
- Reset: rst_n low, dmx_in toggling -> all outputs 0; read_data 0x00 for read_addr 1..512.
- Team transmitter looped back (idle 2500, break 5000, MAB 600), slot1=0x55, slot512=0xAA, rest = addr[7:0] -> 512 slot_valid pulses with addr 1..512 and matching data, one packet_done, slot_count 512, buffer readback matches.
- Start code 0x17 -> no slot_valid, no packet_done, buffer unchanged. The following null packet is received normally.
- Break of 4000 low clocks, then MAB and slots -> ignored (IDLE). Break of 4400 -> packet accepted.
- Break injected after slot 24 -> packet_done, slot_count 24, buffer[25..512] keep previous packet's values.
- Stop bit forced low in slot 3 -> frame_err pulse, slots 1–2 written, slot 3+ not written until the next break. MAB of 300 clocks -> IDLE, no slots.
